// File: rtl/posit_accum_es2.sv
// Sequential ES=2 posit product accumulator: align / add / normalise FSM, one result per sequence.
// Define POSIT_ACCUM_COUNT_EN to add the saturating element counter on out_count.
module posit_accum_es2 #(
    parameter int NBITS = 32,
    parameter int ES    = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [67:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [158:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
`ifdef POSIT_ACCUM_COUNT_EN
    ,
    output logic [15:0]  out_count
`endif
);
    localparam int FRAC_W  = 2 * (NBITS - ES - 2);
    localparam int SCALE_W = ES + 7;
    localparam int MAG_W   = 149;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    state_t                   state_q, state_d;
    logic [MAG_W-1:0]         acc_mag_q, acc_mag_d, op_mag_q, op_mag_d;
    logic signed [9:0]        acc_scale_q, acc_scale_d, op_scale_q, op_scale_d;
    logic                     acc_sgn_q, acc_sgn_d, op_sgn_q, op_sgn_d;
    logic                     acc_inf_q, acc_inf_d, acc_zero_q, acc_zero_d;
    logic                     last_q, last_d;
    logic                     in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [158:0]             out_data_q, out_data_d;
`ifdef POSIT_ACCUM_COUNT_EN
    logic [15:0]              count_q, count_d, out_count_q, out_count_d;
`endif

    logic                     in_sgn, in_inf, in_zero, hs_in;
    logic [SCALE_W-1:0]       in_scale;
    logic [FRAC_W-1:0]        in_frac;
    logic signed [10:0]       diff;
    logic [10:0]              diff_abs;
    logic [7:0]               shamt, lz;
    logic [149:0]             sum;
    logic                     sum_sgn;

    assign in_sgn   = in_data[67];
    assign in_scale = in_data[66 -: SCALE_W];
    assign in_frac  = in_data[2 +: FRAC_W];
    assign in_inf   = in_data[1];
    assign in_zero  = in_data[0];

    function automatic logic [7:0] lead_zeros(input logic [147:0] v);
        logic [7:0] n;
        n = 8'd148;
        for (int i = 0; i < 148; i++)
            if (v[i]) n = 8'(147 - i);
        return n;
    endfunction

    function automatic logic signed [9:0] sat10(input logic signed [10:0] v);
        if (v > 11'sd511) return 10'sd511;
        if (v < -11'sd512) return -10'sd512;
        return v[9:0];
    endfunction

    function automatic logic [8:0] sat9(input logic signed [9:0] v);
        if (v > 10'sd255) return 9'h0FF;
        if (v < -10'sd256) return 9'h100;
        return v[8:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        acc_mag_d   = acc_mag_q;
        acc_scale_d = acc_scale_q;
        acc_sgn_d   = acc_sgn_q;
        acc_inf_d   = acc_inf_q;
        acc_zero_d  = acc_zero_q;
        op_mag_d    = op_mag_q;
        op_scale_d  = op_scale_q;
        op_sgn_d    = op_sgn_q;
        last_d      = last_q;
`ifdef POSIT_ACCUM_COUNT_EN
        count_d     = count_q;
`endif
        hs_in    = in_ready_q && in_valid;
        diff     = {acc_scale_q[9], acc_scale_q} - {op_scale_q[9], op_scale_q};
        diff_abs = diff[10] ? (~diff + 11'd1) : diff;
        shamt    = (diff_abs > 11'd149) ? 8'd149 : diff_abs[7:0];
        lz       = lead_zeros(acc_mag_q[147:0]);
        // Sign-magnitude add; the spare top bit catches the carry of two large operands
        if (acc_sgn_q == op_sgn_q) begin
            sum     = {1'b0, acc_mag_q} + {1'b0, op_mag_q};
            sum_sgn = acc_sgn_q;
        end else if (acc_mag_q >= op_mag_q) begin
            sum     = {1'b0, acc_mag_q} - {1'b0, op_mag_q};
            sum_sgn = acc_sgn_q;
        end else begin
            sum     = {1'b0, op_mag_q} - {1'b0, acc_mag_q};
            sum_sgn = op_sgn_q;
        end

        case (state_q)
            IDLE: if (hs_in) begin
`ifdef POSIT_ACCUM_COUNT_EN
                count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
`endif
                last_d = in_last;
                if (in_zero || acc_inf_q) begin
                    state_d = in_last ? OUT : IDLE;
                end else if (in_inf) begin
                    acc_inf_d = 1'b1;
                    state_d   = in_last ? OUT : IDLE;
                end else if (acc_zero_q) begin
                    acc_sgn_d   = in_sgn;
                    acc_scale_d = {in_scale[SCALE_W-1], in_scale};
                    acc_mag_d   = MAG_W'(in_frac) << 93;
                    acc_zero_d  = 1'b0;
                    state_d     = NORM;
                end else begin
                    op_sgn_d   = in_sgn;
                    op_scale_d = {in_scale[SCALE_W-1], in_scale};
                    op_mag_d   = MAG_W'(in_frac) << 93;
                    state_d    = ALIGN;
                end
            end
            ALIGN: begin
                if (!diff[10]) begin
                    op_mag_d = op_mag_q >> shamt;
                end else begin
                    acc_mag_d   = acc_mag_q >> shamt;
                    acc_scale_d = op_scale_q;
                end
                state_d = ADD;
            end
            ADD: begin
                if (sum == '0) begin
                    acc_mag_d  = '0;
                    acc_zero_d = 1'b1;
                    acc_sgn_d  = 1'b0;
                end else if (sum[149]) begin
                    acc_mag_d   = sum[149:1];
                    acc_scale_d = sat10({acc_scale_q[9], acc_scale_q} + 11'd1);
                    acc_sgn_d   = sum_sgn;
                end else begin
                    acc_mag_d = sum[148:0];
                    acc_sgn_d = sum_sgn;
                end
                state_d = NORM;
            end
            NORM: begin
                if (acc_mag_q[148]) begin
                    acc_mag_d   = acc_mag_q >> 1;
                    acc_scale_d = sat10({acc_scale_q[9], acc_scale_q} + 11'd1);
                end else if (acc_mag_q == '0) begin
                    acc_zero_d = 1'b1;
                end else begin
                    acc_mag_d   = acc_mag_q << lz;
                    acc_scale_d = sat10({acc_scale_q[9], acc_scale_q} - {3'b000, lz});
                end
                state_d = last_q ? OUT : IDLE;
            end
            OUT: if (out_ready) begin
                acc_zero_d = 1'b1;
                acc_inf_d  = 1'b0;
                acc_sgn_d  = 1'b0;
`ifdef POSIT_ACCUM_COUNT_EN
                count_d    = '0;
`endif
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state values so they line up with the state
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
        if (state_d != OUT)  out_data_d = '0;
        else if (acc_inf_d)  out_data_d = {157'd0, 1'b1, 1'b0};
        else if (acc_zero_d) out_data_d = {158'd0, 1'b1};
        else                 out_data_d = {acc_sgn_d, sat9(acc_scale_d), acc_mag_d[146:0], 2'b00};
`ifdef POSIT_ACCUM_COUNT_EN
        out_count_d = (state_d == OUT) ? count_d : 16'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_mag_q   <= '0;
            acc_scale_q <= '0;
            acc_sgn_q   <= 1'b0;
            acc_inf_q   <= 1'b0;
            acc_zero_q  <= 1'b1;
            op_mag_q    <= '0;
            op_scale_q  <= '0;
            op_sgn_q    <= 1'b0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef POSIT_ACCUM_COUNT_EN
            count_q     <= '0;
            out_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_mag_q   <= acc_mag_d;
            acc_scale_q <= acc_scale_d;
            acc_sgn_q   <= acc_sgn_d;
            acc_inf_q   <= acc_inf_d;
            acc_zero_q  <= acc_zero_d;
            op_mag_q    <= op_mag_d;
            op_scale_q  <= op_scale_d;
            op_sgn_q    <= op_sgn_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef POSIT_ACCUM_COUNT_EN
            count_q     <= count_d;
            out_count_q <= out_count_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef POSIT_ACCUM_COUNT_EN
    assign out_count = out_count_q;
`endif
endmodule

// File: tb/tb_posit_accum_es2.sv
// Directed bench for posit_accum_es2: vector table of short sequences plus handshake/reset corner cases.
module tb_posit_accum_es2;
    logic         clk = 1'b0;
    logic         reset;
    logic [67:0]  in_data;
    logic         in_valid, in_last, in_ready;
    logic [158:0] out_data;
    logic         out_valid, out_ready;
`ifdef POSIT_ACCUM_COUNT_EN
    logic [15:0]  out_count;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    posit_accum_es2 dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef POSIT_ACCUM_COUNT_EN
        , .out_count(out_count)
`endif
    );

    typedef struct {
        string        name;
        int           n;
        logic [67:0]  d0;
        logic [67:0]  d1;
        logic [158:0] exp;
        int           cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [67:0] mkIn(input logic sgn, input int scale, input logic [55:0] frac,
                                         input logic inf, input logic zero);
        logic [8:0] s;
        s = 9'(scale);
        return {sgn, s, frac, inf, zero};
    endfunction

    function automatic logic [158:0] mkOut(input logic sgn, input int scale, input logic [146:0] frac,
                                           input logic inf, input logic zero);
        logic [8:0] s;
        s = 9'(scale);
        return {sgn, s, frac, inf, zero};
    endfunction

    function automatic vec_t mkVec(input string name, input int n, input logic [67:0] d0,
                                   input logic [67:0] d1, input logic [158:0] exp, input int cnt);
        vec_t v;
        v.name = name; v.n = n; v.d0 = d0; v.d1 = d1; v.exp = exp; v.cnt = cnt;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [158:0] got, input logic [158:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [67:0] d, input logic last);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checkVal("in_ready timeout", 159'd0, 159'd1);
        end else begin
            in_data  = d;
            in_valid = 1'b1;
            in_last  = last;
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [158:0] exp, input int cnt);
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkVal({name, " out_valid"}, 159'(out_valid), 159'd1);
        if (out_valid) begin
            checkVal({name, " data"}, out_data, exp);
`ifdef POSIT_ACCUM_COUNT_EN
            checkVal({name, " count"}, 159'(out_count), 159'(cnt));
`else
            if (cnt < 0) $display("[TB] negative count in table for %s", name);
`endif
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checkVal({name, " out_valid drop"}, 159'(out_valid), 159'd0);
        end
    endtask

    task automatic countReady(output int n);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [55:0]  f_one, f_three, f_1p5, f_1p75;
        logic [146:0] o_half, o_3q;
        logic [67:0]  one;
        int           w;

        f_one   = 56'd1 << 54;
        f_three = 56'd3 << 54;
        f_1p5   = 56'd3 << 53;
        f_1p75  = 56'd7 << 52;
        o_half  = 147'd1 << 146;
        o_3q    = 147'd3 << 145;
        one     = mkIn(0, 0, f_one, 0, 0);

        vecs.push_back(mkVec("1+1",          2, one, one, mkOut(0, 1, 0, 0, 0), 2));
        vecs.push_back(mkVec("1.5-1.5",      2, mkIn(0, 0, f_1p5, 0, 0), mkIn(1, 0, f_1p5, 0, 0),
                             mkOut(0, 0, 0, 0, 1), 2));
        vecs.push_back(mkVec("s100+s-100",   2, mkIn(0, 100, f_one, 0, 0), mkIn(0, -100, f_one, 0, 0),
                             mkOut(0, 100, 0, 0, 0), 2));
        vecs.push_back(mkVec("3.0 alone",    1, mkIn(0, 0, f_three, 0, 0), 68'd0, mkOut(0, 1, o_half, 0, 0), 1));
        vecs.push_back(mkVec("inf+1",        2, mkIn(0, 0, 0, 1, 0), one, mkOut(0, 0, 0, 1, 0), 2));
        vecs.push_back(mkVec("-1-1",         2, mkIn(1, 0, f_one, 0, 0), mkIn(1, 0, f_one, 0, 0),
                             mkOut(1, 1, 0, 0, 0), 2));
        vecs.push_back(mkVec("1+2",          2, one, mkIn(0, 1, f_one, 0, 0), mkOut(0, 1, o_half, 0, 0), 2));
        vecs.push_back(mkVec("2-1",          2, mkIn(0, 1, f_one, 0, 0), mkIn(1, 0, f_one, 0, 0),
                             mkOut(0, 0, 0, 0, 0), 2));
        vecs.push_back(mkVec("scale sat",    2, mkIn(0, 255, f_one, 0, 0), mkIn(0, 255, f_one, 0, 0),
                             mkOut(0, 255, 0, 0, 0), 2));
        vecs.push_back(mkVec("1+zero",       2, one, mkIn(0, 0, 0, 0, 1), mkOut(0, 0, 0, 0, 0), 2));
        vecs.push_back(mkVec("zero alone",   1, mkIn(0, 0, 0, 0, 1), 68'd0, mkOut(0, 0, 0, 0, 1), 1));
        vecs.push_back(mkVec("1.75 alone",   1, mkIn(0, 0, f_1p75, 0, 0), 68'd0, mkOut(0, 0, o_3q, 0, 0), 1));

        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("reset in_ready", 159'(in_ready), 159'd0);
        checkVal("reset out_valid", 159'(out_valid), 159'd0);
        checkVal("reset out_data", out_data, 159'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].d0, vecs[i].n == 1);
            if (vecs[i].n == 2) applyStimulus(vecs[i].d1, 1'b1);
            checkOutput(vecs[i].name, vecs[i].exp, vecs[i].cnt);
        end

        // Element latency: first element loads directly, later ones run the full align/add/norm path
        applyStimulus(one, 1'b0);
        countReady(w);
        checkVal("first elem latency", 159'(w), 159'd1);
        applyStimulus(one, 1'b0);
        countReady(w);
        checkVal("normal elem latency", 159'(w), 159'd3);
        applyStimulus(one, 1'b1);
        checkOutput("1+1+1", mkOut(0, 1, o_half, 0, 0), 3);

        // Output back-pressure with a pending input that must wait for IDLE
        applyStimulus(one, 1'b1);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_data = mkIn(0, 0, f_three, 0, 0); in_last = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checkVal("stall out_data", out_data, mkOut(0, 0, 0, 0, 0));
            checkVal("stall in_ready", 159'(in_ready), 159'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkVal("post stall out_valid", 159'(out_valid), 159'd0);
        checkVal("post stall in_ready", 159'(in_ready), 159'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checkOutput("after stall", mkOut(0, 1, o_half, 0, 0), 1);

        // Reset while the second element sits in ALIGN
        applyStimulus(one, 1'b0);
        applyStimulus(mkIn(0, 3, f_one, 0, 0), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checkVal("mid reset out_valid", 159'(out_valid), 159'd0);
        checkVal("mid reset in_ready", 159'(in_ready), 159'd0);
        reset = 1'b0;
        applyStimulus(one, 1'b1);
        checkOutput("after reset", mkOut(0, 0, 0, 0, 0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
